// File: rtl/serial_packet_rx.sv
// serial_packet_rx: LSB-first serial word receiver with packet framing
// (length, payload, XOR checksum) feeding a valid/ready output FIFO.
//
// Ports:
//   tClk         single clock, rising edge
//   rst          synchronous active-high reset
//   Dout         serial data bit, LSB first
//   Dout_Valid   Dout is sampled on every edge where this is high
//   out_data     FIFO head word (zero while the FIFO is empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer accept; pop on out_valid && out_ready
//   out_last     head word is the final payload word of its packet
//   Receive_flag one-cycle pulse per completed word
//   pkt_done     one-cycle pulse on a packet with a good checksum
//   pkt_err      one-cycle pulse on bad checksum, framing or overflow
//   fifo_level   current FIFO occupancy
module serial_packet_rx #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        tClk,
    input  logic                        rst,
    input  logic                        Dout,
    input  logic                        Dout_Valid,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        Receive_flag,
    output logic                        pkt_done,
    output logic                        pkt_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [WORD_W-1:0] ONE_W   = WORD_W'(1);

    localparam logic [1:0] ST_LEN     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHK     = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic [WORD_W-1:0] xor_q, xor_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rflag_q, rflag_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Each entry holds {last, data}
    logic [WORD_W:0]   mem_q [FIFO_DEPTH];

    logic              word_done;
    logic              push;
    logic              push_last;
    logic              pop;
    logic              full;
    logic [WORD_W:0]   head;

    assign out_valid    = (level_q != '0);
    assign full         = (level_q == FULL_LVL);
    assign pop          = out_valid && out_ready;
    assign head         = mem_q[rptr_q];
    assign out_data     = out_valid ? head[WORD_W-1:0] : '0;
    assign out_last     = out_valid & head[WORD_W];
    assign fifo_level   = level_q;
    assign Receive_flag = rflag_q;
    assign pkt_done     = done_q;
    assign pkt_err      = err_q;

    // Bit collection and packet FSM
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        count_d   = count_q;
        xor_d     = xor_q;
        rflag_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        word_done = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;

        if (!Dout_Valid) begin
            bit_cnt_d = '0;
            if (state_q == ST_DRAIN) begin
                state_d = ST_LEN;
            end else if (bit_cnt_q != '0) begin
                // Valid dropped inside a word: framing error
                err_d   = 1'b1;
                state_d = ST_DRAIN;
            end
        end else if (state_q != ST_DRAIN) begin
            // LSB first: after WORD_W shifts bit 0 is the first bit
            shift_d = {Dout, shift_q[WORD_W-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (word_done) begin
            rflag_d = 1'b1;
            unique case (state_q)
                ST_LEN: begin
                    count_d = shift_d;
                    xor_d   = '0;
                    state_d = (shift_d == '0) ? ST_CHK : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    // A pop on the same edge frees the head slot
                    if (full && !pop) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        push      = 1'b1;
                        push_last = (count_q == ONE_W);
                        xor_d     = xor_q ^ shift_d;
                        count_d   = count_q - ONE_W;
                        if (count_q == ONE_W) begin
                            state_d = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (shift_d == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_LEN;
                end
                default: begin
                    state_d = ST_DRAIN;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge tClk) begin
        if (rst) begin
            state_q   <= ST_LEN;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            xor_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rflag_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            xor_q     <= xor_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rflag_q   <= rflag_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset; occupancy gates what is visible
    always_ff @(posedge tClk) begin
        if (push && !rst) begin
            mem_q[wptr_q] <= {push_last, shift_d};
        end
    end

endmodule

// File: tb/tb_serial_packet_rx.sv
// tb_serial_packet_rx: scoreboard bench for serial_packet_rx
// (directed packets, framing/overflow/reset cases, random packets).
module tb_serial_packet_rx;

    localparam int W = 8;
    localparam int D = 4;

    logic tClk = 1'b0;
    logic rst = 1'b1;
    logic Dout = 1'b0;
    logic Dout_Valid = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic out_valid;
    logic out_last;
    logic Receive_flag;
    logic pkt_done;
    logic pkt_err;
    logic [$clog2(D):0] fifo_level;

    int checks = 0;
    int errors = 0;
    int rf_seen = 0;
    int rf_exp = 0;
    int rdy_mode = 1;

    logic [W:0] exp_q [$];
    bit ev_q [$];

    always #5 tClk = ~tClk;

    serial_packet_rx #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
        .tClk(tClk),
        .rst(rst),
        .Dout(Dout),
        .Dout_Valid(Dout_Valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .Receive_flag(Receive_flag),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err),
        .fifo_level(fifo_level)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic v, input logic b);
        @(posedge tClk);
        #1;
        Dout_Valid = v;
        Dout = b;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) cyc(1'b1, w[k]);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
    endtask

    // Reference: a packet pushes its payload in order, the last one
    // flagged, until the FIFO capacity is used up; an overflowing word
    // still completes, then the rest of the packet is ignored.
    task automatic packet(input logic [W-1:0] pl [$],
                          input logic [W-1:0] chk_w, input int cap);
        logic [W-1:0] x;
        bit ovf;
        int len;
        x = '0;
        ovf = 1'b0;
        len = pl.size();
        rf_exp++;
        foreach (pl[j]) begin
            if (!ovf) begin
                rf_exp++;
                if (j >= cap) begin
                    ovf = 1'b1;
                end else begin
                    exp_q.push_back({(j == len - 1), pl[j]});
                    x ^= pl[j];
                end
            end
        end
        if (ovf) begin
            ev_q.push_back(1'b0);
        end else begin
            rf_exp++;
            ev_q.push_back(chk_w == x);
        end
        send_word(W'(len));
        foreach (pl[j]) send_word(pl[j]);
        send_word(chk_w);
        gap(3);
    endtask

    // Full words in pl, then nbits of a word before Dout_Valid drops
    task automatic framed(input int len, input logic [W-1:0] pl [$],
                          input int nbits, input logic [W-1:0] part);
        rf_exp += 1 + pl.size();
        foreach (pl[j]) exp_q.push_back({(j == len - 1), pl[j]});
        ev_q.push_back(1'b0);
        send_word(W'(len));
        foreach (pl[j]) send_word(pl[j]);
        for (int k = 0; k < nbits; k++) cyc(1'b1, part[k]);
        gap(3);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_out_data"}, int'(out_data), 0);
        chk({name, "_out_last"}, int'(out_last), 0);
        chk({name, "_rflag"}, int'(Receive_flag), 0);
        chk({name, "_pkt_done"}, int'(pkt_done), 0);
        chk({name, "_pkt_err"}, int'(pkt_err), 0);
        chk({name, "_level"}, int'(fifo_level), 0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 400) begin
            @(negedge tClk);
            n++;
        end
        repeat (2) @(negedge tClk);
        chk({name, "_words_left"}, exp_q.size(), 0);
        chk({name, "_events_left"}, ev_q.size(), 0);
        chk({name, "_rflags"}, rf_seen, rf_exp);
        chk({name, "_level"}, int'(fifo_level), 0);
    endtask

    // Consumer ready driver
    initial begin
        forever begin
            @(posedge tClk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents output
    initial begin : mon
        logic [W:0] e;
        bit ev;
        forever begin
            @(negedge tClk);
            if (!rst) begin
                if (Receive_flag) rf_seen++;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL fifo_word: got last=%0b data=%02h, required no word",
                                 out_last, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_last, out_data} !== e) begin
                            errors++;
                            $display("FAIL fifo_word: got last=%0b data=%02h, required last=%0b data=%02h",
                                     out_last, out_data, e[W], e[W-1:0]);
                        end
                    end
                end
                if (pkt_done || pkt_err) begin
                    checks++;
                    if (pkt_done && pkt_err) begin
                        errors++;
                        $display("FAIL pkt_status: got done=1 err=1, required exclusive");
                    end else if (ev_q.size() == 0) begin
                        errors++;
                        $display("FAIL pkt_status: got done=%0b err=%0b, required no event",
                                 pkt_done, pkt_err);
                    end else begin
                        ev = ev_q.pop_front();
                        if (pkt_done != ev) begin
                            errors++;
                            $display("FAIL pkt_status: got done=%0b err=%0b, required done=%0b err=%0b",
                                     pkt_done, pkt_err, ev, !ev);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] q [$];
        logic [W-1:0] c;
        logic [W-1:0] x;
        logic [W-1:0] part;
        int len;
        int k;

        rst = 1'b1;
        rdy_mode = 1;
        repeat (3) @(posedge tClk);
        @(negedge tClk);
        check_zero("reset");
        @(posedge tClk);
        #1 rst = 1'b0;
        gap(2);

        q = {8'hA5, 8'h3C};
        packet(q, 8'h99, 1000);
        drain("good_pkt");

        q = {8'hA5, 8'h3C};
        packet(q, 8'h00, 1000);
        drain("bad_chk");

        q.delete();
        packet(q, 8'h00, 1000);
        q = {8'h7E};
        packet(q, 8'h7E, 1000);
        drain("zero_len");

        q = {8'h11};
        framed(2, q, 5, 8'h5A);
        q = {8'hC3, 8'h3C, 8'h0F};
        packet(q, 8'hF0, 1000);
        drain("framing");

        rdy_mode = 0;
        gap(3);
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        packet(q, 8'h07, D);
        @(negedge tClk);
        chk("overflow_level", int'(fifo_level), D);
        rdy_mode = 1;
        drain("overflow");

        exp_q.push_back({1'b0, 8'hA5});
        rf_exp += 2;
        send_word(8'h02);
        send_word(8'hA5);
        part = 8'h3C;
        for (int b = 0; b < 3; b++) cyc(1'b1, part[b]);
        @(posedge tClk);
        #1;
        rst = 1'b1;
        Dout_Valid = 1'b0;
        @(negedge tClk);
        check_zero("mid_reset");
        exp_q.delete();
        @(posedge tClk);
        #1 rst = 1'b0;
        gap(2);
        q = {8'h3C, 8'hC3};
        packet(q, 8'hFF, 1000);
        drain("after_reset");

        rdy_mode = 2;
        for (int p = 0; p < 24; p++) begin
            q.delete();
            if ($urandom_range(0, 5) == 0) begin
                len = $urandom_range(1, 5);
                k = $urandom_range(0, len - 1);
                for (int j = 0; j < k; j++) q.push_back(W'($urandom));
                part = W'($urandom);
                framed(len, q, $urandom_range(1, W - 1), part);
            end else begin
                len = $urandom_range(0, 5);
                x = '0;
                for (int j = 0; j < len; j++) begin
                    c = W'($urandom);
                    q.push_back(c);
                    x ^= c;
                end
                c = ($urandom_range(0, 3) != 0) ? x : W'($urandom);
                packet(q, c, 1000);
            end
        end
        rdy_mode = 1;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_packet_rx.md
SERIAL_PACKET_RX -- requirements
Module: serial_packet_rx

Parameters
REQ-001 SHALL have parameter WORD_W, default 8, giving the serial word width in bits (4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the output FIFO depth in words (power of 2, 2..256).

Interface
REQ-003 SHALL have port tClk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Dout, input, 1 bit: serial data, LSB-first.
REQ-006 SHALL have port Dout_Valid, input, 1 bit: Dout is sampled on every tClk edge where this is high.
REQ-007 SHALL have port out_data, output, WORD_W bits: the FIFO head word.
REQ-008 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accept; a pop occurs when out_valid && out_ready.
REQ-010 SHALL have port out_last, output, 1 bit: the head word is the final payload word of its packet.
REQ-011 SHALL have port Receive_flag, output, 1 bit: one-cycle pulse on each completed word, including the length and checksum words.
REQ-012 SHALL have port pkt_done, output, 1 bit: one-cycle pulse when a packet ends with a good checksum.
REQ-013 SHALL have port pkt_err, output, 1 bit: one-cycle pulse on a bad checksum, a framing error or an overflow.
REQ-014 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-015 SHALL shift in one Dout bit per Dout_Valid cycle into bit index i (0..WORD_W-1); a word completes on the cycle i reaches WORD_W-1, and Receive_flag is registered and asserts the following cycle.
REQ-016 SHALL implement an FSM with states LEN, PAYLOAD, CHK and DRAIN; the FSM resets to LEN.
REQ-017 SHALL, in LEN, treat the completed word as length L (0..2^WORD_W-1), load the remaining count to L, clear the running XOR, and go to PAYLOAD if L>0 or to CHK if L=0.
REQ-018 SHALL, in PAYLOAD, push each completed word to the FIFO, XOR it into the checksum and decrement the count; the word that brings the count to 0 is pushed with last=1 and the FSM goes to CHK.
REQ-019 SHALL, in CHK, compare the completed word to the running XOR: on a match, pulse pkt_done; on a mismatch, pulse pkt_err; in both cases return to LEN.
REQ-020 SHALL treat Dout_Valid falling while 0<i<WORD_W as a framing error: discard the partial word, reset i to 0, pulse pkt_err, and go to DRAIN.
REQ-021 SHALL, in DRAIN, ignore input until Dout_Valid has been low for at least one cycle, and then go to LEN.
REQ-022 SHALL reset i to 0 on any cycle where Dout_Valid is low, in every state.
REQ-023 SHALL, when a PAYLOAD word completes with the FIFO full and no simultaneous pop, drop the word, pulse pkt_err, and go to DRAIN; a simultaneous pop and push when full SHALL be accepted.
REQ-024 SHALL, on a simultaneous push and pop, leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 SHALL show out_data and out_last combinationally from the FIFO head; a pushed word is visible on out_valid the cycle after its push.
REQ-026 SHALL keep words already pushed from an errored packet in the FIFO; the consumer uses pkt_err to discard them.
REQ-027 SHALL assert pkt_done and pkt_err mutually exclusively; Receive_flag MAY coincide with either.

Reset
REQ-028 SHALL, while rst is high, set FSM=LEN, i=0, count=0, XOR=0, FIFO pointers=0, fifo_level=0, out_valid=0, and out_last, Receive_flag, pkt_done and pkt_err all 0.
REQ-029 SHALL give rst priority over all inputs; a reset mid-packet discards the partial packet and the FIFO contents.

Verification
REQ-030 SHALL cover this case with WORD_W=8: serial words 0x02, 0xA5, 0x3C, 0x99 with out_ready=1 -> FIFO outputs 0xA5, then 0x3C with out_last=1; pkt_done pulses once; four Receive_flag pulses.
REQ-031 SHALL cover this case: 0x02, 0xA5, 0x3C, 0x00 -> both payload words are delivered and pkt_err pulses once with no pkt_done.
REQ-032 SHALL cover this case: 0x00, 0x00 -> no FIFO push and pkt_done pulses; then 0x01, 0x7E, 0x7E -> 0x7E is delivered with out_last=1.
REQ-033 SHALL cover this case: Dout_Valid drops after 5 bits of a payload word -> pkt_err pulses, that word is never pushed, and the next clean packet is received correctly.
REQ-034 SHALL cover this case with FIFO_DEPTH=4: a length-6 packet with out_ready=0 -> fifo_level reaches 4, pkt_err pulses on the 5th word, and after out_ready=1 exactly 4 words drain.
REQ-035 SHALL cover this case: rst asserted after the 3rd bit of a payload word -> all outputs 0 the next cycle, and a following packet is received intact.
